// File: rtl/fir_ctrl_if.sv
// AXI-lite configuration bus between the host and fir_ctrl.
// slave: the register front end (fir_ctrl); master: the host / bench driver.
interface fir_ctrl_if #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata
    );
endinterface

// File: rtl/fir_ctrl.sv
// fir_ctrl: AXI-lite register front end and ap_ctrl sequencer for the FIR engine.
// Owns the tap BRAM port and arbitrates it: engine fetch > AXI write > AXI read.
// Optional build macro FIR_CTRL_CYCLE_CNT_EN adds a read-only RUN cycle counter at 0x14.
module fir_ctrl #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    fir_ctrl_if.slave              axi,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   eng_start,
    output logic [31:0]            eng_len,
    input  logic                   eng_tap_req,
    input  logic [3:0]             eng_tap_idx,
    output logic                   eng_tap_vld,
    input  logic                   eng_done
);

    localparam logic [pADDR_WIDTH-1:0] AddrCtrl   = pADDR_WIDTH'(32'h00);
    localparam logic [pADDR_WIDTH-1:0] AddrLen    = pADDR_WIDTH'(32'h10);
    localparam logic [pADDR_WIDTH-1:0] AddrTap    = pADDR_WIDTH'(32'h20);
    localparam logic [pADDR_WIDTH-1:0] AddrTapEnd = pADDR_WIDTH'(32'h20 + 4 * Tape_Num);
`ifdef FIR_CTRL_CYCLE_CNT_EN
    localparam logic [pADDR_WIDTH-1:0] AddrCnt    = pADDR_WIDTH'(32'h14);
`endif

    typedef enum logic [1:0] {StIdle, StStart, StRun} state_e;

    state_e                 r_state, w_state_d;
    logic                   r_ap_idle, r_ap_done;
    logic [31:0]            r_len;
    logic                   r_wr_ack;
    logic                   r_rvalid, r_rd_pend, r_rd_ctrl;
    logic [pDATA_WIDTH-1:0] r_rdata;
    logic                   r_eng_vld;

    logic                   w_idle, w_wr_req, w_wr_tap, w_wr_bram_need, w_wr_fire, w_wr_bram;
    logic                   w_rd_tap, w_rd_fire, w_rd_hs;
    logic [pADDR_WIDTH-1:0] w_wr_off, w_rd_off;
    logic [pDATA_WIDTH-1:0] w_reg_rdata;
`ifdef FIR_CTRL_CYCLE_CNT_EN
    logic [31:0]            r_cyc_cnt;
`endif

    // Address decode, handshake qualification and BRAM conflict detection.
    always_comb begin
        w_idle         = (r_state == StIdle);
        // r_wr_ack enforces at most one write every two cycles.
        w_wr_req       = axi.awvalid && axi.wvalid && !r_wr_ack && !axis_rst;
        w_wr_tap       = (axi.awaddr >= AddrTap) && (axi.awaddr < AddrTapEnd);
        // Tap writes outside IDLE are dropped, so they never need the BRAM.
        w_wr_bram_need = w_wr_tap && w_idle;
        w_wr_fire      = w_wr_req && !(w_wr_bram_need && eng_tap_req);
        w_wr_bram      = w_wr_fire && w_wr_bram_need;
        w_wr_off       = axi.awaddr - AddrTap;
        w_rd_tap       = (axi.araddr >= AddrTap) && (axi.araddr < AddrTapEnd);
        w_rd_off       = axi.araddr - AddrTap;
        w_rd_fire      = axi.arvalid && !r_rvalid && !r_rd_pend && !axis_rst &&
                         !(w_rd_tap && (eng_tap_req || w_wr_bram));
        w_rd_hs        = r_rvalid && axi.rready;
    end

    // Register-space read mux (ctrl status is presented live at the output instead).
    always_comb begin
        w_reg_rdata = '0;
        if (axi.araddr == AddrLen) begin
            w_reg_rdata = pDATA_WIDTH'(r_len);
        end
`ifdef FIR_CTRL_CYCLE_CNT_EN
        if (axi.araddr == AddrCnt) begin
            w_reg_rdata = pDATA_WIDTH'(r_cyc_cnt);
        end
`endif
    end

    // Tap BRAM port: fixed-priority mux between engine fetch, AXI write and AXI read.
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_Di = '0;
        tap_A  = '0;
        if (eng_tap_req) begin
            tap_EN = 1'b1;
            tap_A  = pADDR_WIDTH'({eng_tap_idx, 2'b00});
        end else if (w_wr_bram) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_Di = axi.wdata;
            tap_A  = {w_wr_off[pADDR_WIDTH-1:2], 2'b00};
        end else if (w_rd_fire && w_rd_tap) begin
            tap_EN = 1'b1;
            tap_A  = {w_rd_off[pADDR_WIDTH-1:2], 2'b00};
        end
    end

    // AXI-lite outputs; ctrl reads show live status so the done bit returned is the one cleared.
    always_comb begin
        axi.awready = w_wr_fire;
        axi.wready  = w_wr_fire;
        axi.arready = w_rd_fire;
        axi.rvalid  = r_rvalid;
        axi.rdata   = r_rd_ctrl ?
                      pDATA_WIDTH'({r_ap_idle, r_ap_done, r_state == StStart}) : r_rdata;
        eng_len     = r_len;
        eng_tap_vld = r_eng_vld;
    end

    // ap_ctrl sequencer next state and start pulse.
    always_comb begin
        w_state_d = r_state;
        eng_start = 1'b0;
        unique case (r_state)
            StIdle:  if (w_wr_fire && axi.awaddr == AddrCtrl && axi.wdata[0]) w_state_d = StStart;
            StStart: begin
                eng_start = 1'b1;
                w_state_d = StRun;
            end
            StRun:   if (eng_done) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State, status bits, config registers and read-channel pipeline.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_state   <= StIdle;
            r_ap_idle <= 1'b1;
            r_ap_done <= 1'b0;
            r_len     <= '0;
            r_wr_ack  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rd_ctrl <= 1'b0;
            r_rdata   <= '0;
            r_eng_vld <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_wr_ack  <= w_wr_fire;
            r_eng_vld <= eng_tap_req;
            if (r_state == StStart) r_ap_idle <= 1'b0;
            if (r_state == StRun && eng_done) r_ap_idle <= 1'b1;
            // Set beats clear when eng_done coincides with the clearing read.
            if (r_state == StRun && eng_done) begin
                r_ap_done <= 1'b1;
            end else if (w_rd_hs && r_rd_ctrl) begin
                r_ap_done <= 1'b0;
            end
            if (w_wr_fire && w_idle && axi.awaddr == AddrLen) r_len <= 32'(axi.wdata);
            if (w_rd_hs) begin
                r_rvalid  <= 1'b0;
                r_rd_ctrl <= 1'b0;
            end
            if (r_rd_pend) begin
                r_rd_pend <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= tap_Do;
            end
            if (w_rd_fire) begin
                if (w_rd_tap) begin
                    r_rd_pend <= 1'b1;
                end else begin
                    r_rvalid  <= 1'b1;
                    r_rdata   <= w_reg_rdata;
                    r_rd_ctrl <= (axi.araddr == AddrCtrl);
                end
            end
        end
    end

`ifdef FIR_CTRL_CYCLE_CNT_EN
    // RUN cycle counter: cleared on START, frozen outside RUN, saturating.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_cyc_cnt <= '0;
        end else if (r_state == StStart) begin
            r_cyc_cnt <= '0;
        end else if (r_state == StRun && r_cyc_cnt != 32'hFFFF_FFFF) begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl with a behavioural 1-cycle-latency tap BRAM.
module tb_fir_ctrl;

    logic        axis_clk;
    logic        axis_rst;
    logic [3:0]  tap_WE;
    logic        tap_EN;
    logic [31:0] tap_Di;
    logic [11:0] tap_A;
    logic [31:0] tap_Do;
    logic        eng_start;
    logic [31:0] eng_len;
    logic        eng_tap_req;
    logic [3:0]  eng_tap_idx;
    logic        eng_tap_vld;
    logic        eng_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] tap_mem [0:15];
    int          taps [0:10] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    fir_ctrl_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

    fir_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
        .axis_clk    (axis_clk),
        .axis_rst    (axis_rst),
        .axi         (bus),
        .tap_WE      (tap_WE),
        .tap_EN      (tap_EN),
        .tap_Di      (tap_Di),
        .tap_A       (tap_A),
        .tap_Do      (tap_Do),
        .eng_start   (eng_start),
        .eng_len     (eng_len),
        .eng_tap_req (eng_tap_req),
        .eng_tap_idx (eng_tap_idx),
        .eng_tap_vld (eng_tap_vld),
        .eng_done    (eng_done)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    initial begin
        for (int i = 0; i < 16; i++) tap_mem[i] = '0;
    end

    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) tap_mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= tap_mem[tap_A[5:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data);
        int n = 0;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        #1;
        while (!bus.awready && n < 50) begin
            @(posedge axis_clk); #1;
            n++;
        end
        if (!bus.awready) check("aw_timeout", 32'(bus.awready), 32'd1);
        else check("wready_with_awready", 32'(bus.wready), 32'd1);
        @(posedge axis_clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data);
        int n = 0;
        data        = 32'hDEAD_BEEF;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        #1;
        while (!bus.arready && n < 50) begin
            @(posedge axis_clk); #1;
            n++;
        end
        if (!bus.arready) begin
            check("ar_timeout", 32'(bus.arready), 32'd1);
            bus.arvalid = 1'b0;
            return;
        end
        @(posedge axis_clk); #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        n = 0;
        while (!bus.rvalid && n < 50) begin
            @(posedge axis_clk); #1;
            n++;
        end
        if (!bus.rvalid) begin
            check("r_timeout", 32'(bus.rvalid), 32'd1);
        end else begin
            data = bus.rdata;
            @(posedge axis_clk); #1;
        end
        bus.rready = 1'b0;
    endtask

    task automatic pulse_done();
        eng_done = 1'b1;
        @(posedge axis_clk); #1;
        eng_done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
        eng_tap_req = 0; eng_tap_idx = 0; eng_done = 0;
        axis_rst = 1'b1;
        repeat (3) @(posedge axis_clk);
        #1;
        axis_rst = 1'b0;
        #1;

        // Reset state
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_eng_len", eng_len, 32'd0);
        check("rst_tap_vld", 32'(eng_tap_vld), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        axi_read(12'h000, d); check("rst_ctrl", d & 32'hF, 32'h4);
        axi_read(12'h010, d); check("rst_len", d, 32'd0);

        // Config writes and read-back
        axi_write(12'h010, 32'd600);
        for (int i = 0; i < 11; i++) axi_write(12'(32'h20 + 4 * i), 32'(taps[i]));
        axi_read(12'h010, d); check("len_600", d, 32'd600);
        for (int i = 0; i < 11; i++) begin
            axi_read(12'(32'h20 + 4 * i), d);
            check($sformatf("tap%0d", i), d, 32'(taps[i]));
        end
        axi_write(12'h04C, 32'h1234);
        axi_read(12'h04C, d); check("unmapped_4c", d, 32'd0);
        axi_read(12'h048, d); check("tap10_intact", d, 32'd0);
        axi_read(12'h014, d); check("cnt_idle_zero", d, 32'd0);

        // Start: one-cycle pulse, RUN status, writes dropped
        axi_write(12'h000, 32'd1);
        check("start_pulse", 32'(eng_start), 32'd1);
        @(posedge axis_clk); #1;
        check("start_pulse_end", 32'(eng_start), 32'd0);
        axi_read(12'h000, d); check("run_ctrl", d & 32'hF, 32'h0);
        axi_write(12'h010, 32'd5);
        axi_read(12'h010, d); check("len_locked", d, 32'd600);
        check("eng_len_run", eng_len, 32'd600);
        axi_write(12'h020, 32'd99);
        axi_write(12'h000, 32'd1);
        check("restart_ignored", 32'(eng_start), 32'd0);

        // Engine tap fetch has priority over an AXI tap read
        eng_tap_req = 1'b1; eng_tap_idx = 4'd5;
        bus.araddr = 12'h034; bus.arvalid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("ar_stalled", 32'(bus.arready), 32'd0);
            @(posedge axis_clk); #1;
            check("eng_vld", 32'(eng_tap_vld), 32'd1);
            check("eng_tap5", tap_Do, 32'd63);
        end
        eng_tap_req = 1'b0;
        #1;
        check("ar_after_drop", 32'(bus.arready), 32'd1);
        @(posedge axis_clk); #1;
        check("eng_vld_drop", 32'(eng_tap_vld), 32'd0);
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        begin
            int n = 0;
            while (!bus.rvalid && n < 10) begin
                @(posedge axis_clk); #1;
                n++;
            end
        end
        check("axi_tap5", bus.rdata, 32'd63);
        @(posedge axis_clk); #1;
        bus.rready = 1'b0;

        // Done: clear-on-read, then restart with same taps
        pulse_done();
        axi_read(12'h000, d); check("done_ctrl", d & 32'hF, 32'h6);
        axi_read(12'h000, d); check("done_cleared", d & 32'hF, 32'h4);
        axi_read(12'h020, d); check("tap0_run_drop", d, 32'd0);
        axi_write(12'h000, 32'd1);
        check("restart_pulse", 32'(eng_start), 32'd1);
        axi_read(12'h02C, d); check("restart_tap3", d, 32'd23);
        pulse_done();
        axi_read(12'h000, d); check("done2_ctrl", d & 32'hF, 32'h6);

        // RUN cycle counter
        axi_write(12'h000, 32'd1);
        repeat (100) @(posedge axis_clk);
        #1;
        pulse_done();
        axi_read(12'h014, d);
`ifdef FIR_CTRL_CYCLE_CNT_EN
        check("cyc_cnt_100", 32'(d >= 32'd99 && d <= 32'd101), 32'd1);
        repeat (5) @(posedge axis_clk);
        #1;
        axi_read(12'h014, d);
        check("cyc_cnt_frozen", 32'(d >= 32'd99 && d <= 32'd101), 32'd1);
`else
        check("cnt_unmapped", d, 32'd0);
`endif
        axi_read(12'h000, d); check("done3_ctrl", d & 32'hF, 32'h6);

        // Reset mid-RUN
        axi_write(12'h000, 32'd1);
        repeat (5) @(posedge axis_clk);
        #1;
        axis_rst = 1'b1;
        @(posedge axis_clk); #1;
        axis_rst = 1'b0;
        check("rst_run_eng_len", eng_len, 32'd0);
        axi_read(12'h000, d); check("rst_run_ctrl", d & 32'hF, 32'h4);
        axi_read(12'h010, d); check("rst_run_len", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
